// File: rtl/serial_sub5.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, with a start/busy/done handshake.
// Optional macro SERIAL_SUB_OVF_EN adds the two's-complement overflow output ovf.
`timescale 1ns/1ps
module serial_sub5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit_s;
  logic             borrow_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One full-subtractor cell operating on the current LSBs.
  assign d_bit_s      = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_nxt_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = {CW{1'b0}};
          res_d    = {(WIDTH-1){1'b0}};
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_nxt_s;
        cnt_d    = cnt_q + CW'(1);
        // Keep only the WIDTH-1 most recent bits; the final bit goes straight to diff.
        res_d    = (WIDTH-1)'({d_bit_s, res_q} >> 1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {d_bit_s, res_q};
          bout_d  = borrow_nxt_s;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = borrow_q ^ borrow_nxt_s;
`endif
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = {CW{1'b0}};
          res_d    = {(WIDTH-1){1'b0}};
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      res_q    <= {(WIDTH-1){1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub5.sv
// Scoreboard bench for serial_sub5: driver pushes model results, a negedge monitor checks each done pulse.
`timescale 1ns/1ps
module tb_serial_sub5;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub5 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    longint       t;
  } exp_t;

  exp_t         q[$];
  exp_t         me;
  int           compared = 0;
  int           mismatched = 0;
  int           bcnt = 0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi);
    exp_t e;
    int   r, sa, sb, rs;
    r  = int'(ta) - int'(tb_) - int'(tbi);
    e.diff = r[W-1:0];
    e.bout = (int'(ta) < int'(tb_) + int'(tbi));
    sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb = tb_[W-1] ? int'(tb_) - (1 << W) : int'(tb_);
    rs = sa - sb - int'(tbi);
    e.ovf = (rs < -(1 << (W-1))) || (rs > (1 << (W-1)) - 1);
    e.t = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive start for one edge; that edge accepts (DUT is in IDLE or DONE).
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi, input bit push);
    exp_t e;
    a = ta; b = tb_; bin = tbi; start = 1'b1;
    @(posedge clk);
    if (push) begin
      e = model(ta, tb_, tbi);
      e.t = longint'($time) + W * 10 + 5;
      q.push_back(e);
    end
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi);
    issue(ta, tb_, tbi, 1'b1);
    repeat (W) @(posedge clk);
    #1;
  endtask

  // Monitor: hold check while busy, scoreboard compare on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      held_diff = '0; held_bout = 1'b0; bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
        compared++;
        if ({held_bout, held_diff} !== {bout, diff}) begin
          mismatched++;
          $display("FAIL hold_while_busy: got %0h required %0h at %0t", {bout, diff}, {held_bout, held_diff}, $time);
        end
      end
      if (done) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got done=1 required no pending op at %0t", $time);
        end else begin
          me = q.pop_front();
          if ({bout, diff} !== {me.bout, me.diff}) begin
            mismatched++;
            $display("FAIL result: got %0h required %0h at %0t", {bout, diff}, {me.bout, me.diff}, $time);
          end
          compared++;
          if (longint'($time) != me.t) begin
            mismatched++;
            $display("FAIL latency: done at %0t required %0d", $time, me.t);
          end
          compared++;
          if (bcnt != W) begin
            mismatched++;
            $display("FAIL busy_cycles: got %0d required %0d at %0t", bcnt, W, $time);
          end
`ifdef SERIAL_SUB_OVF_EN
          compared++;
          if (ovf !== me.ovf) begin
            mismatched++;
            $display("FAIL ovf: got %0b required %0b at %0t", ovf, me.ovf, $time);
          end
`endif
          held_diff = me.diff;
          held_bout = me.bout;
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    chk("reset_outputs", {busy, done, bout, diff[W-3:0]}, '0);
    chk("reset_diff", {1'b0, diff}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(5'b10100, 5'b10010, 1'b0);
    run_op(5'b00110, 5'b01100, 1'b1);
    run_op(5'b00000, 5'b00000, 1'b1);
    run_op(5'b10000, 5'b00001, 1'b0);
    run_op(5'b11111, 5'b00000, 1'b0);

    // Back-to-back with start held high.
    a = 5'b11111; b = 5'b00001; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    me = model(5'b11111, 5'b00001, 1'b0);
    me.t = longint'($time) + W * 10 + 5;
    q.push_back(me);
    #1;
    a = 5'b00001; b = 5'b00010; bin = 1'b0;
    repeat (W + 1) @(posedge clk);
    me = model(5'b00001, 5'b00010, 1'b0);
    me.t = longint'($time) + W * 10 + 5;
    q.push_back(me);
    #1;
    start = 1'b0;
    repeat (W) @(posedge clk);
    #1;

    // Start pulsed mid-RUN with other operands is ignored.
    issue(5'b01011, 5'b00101, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1; a = 5'b11100; b = 5'b00011; bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W - 2) @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    // Reset on the third RUN cycle aborts the operation with no done.
    issue(5'b00011, 5'b00111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrun_reset_flags", {{(W-1){1'b0}}, busy, done}, '0);
    chk("midrun_reset_result", {bout, diff}, '0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_idle", {bout, diff}, '0);
    run_op(5'b01001, 5'b00100, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending results required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_sub5.md
Name: serial_sub5

Overview:
- Bit-serial subtractor; the inverse datapath of the team's 5-bit ripple full adder.
- Computes diff = a - b - bin one bit per clock, LSB first, through a single 1-bit full-subtractor cell.
- Reports the result with a start/busy/done handshake.
- Used where adder area must be traded for latency, and as a sequential cross-check against the combinational adder.

Parameters:
- WIDTH, 5, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; diff/bout valid from this cycle onward
- diff  output  WIDTH  result, held until the next accepted start
- bout  output  1  borrow-out: 1 when unsigned a < b + bin

Behaviour:
- Reset: async on rst=1.
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load shift regs A<=a, B<=b, borrow<=bin, cnt<=0; go to RUN. Otherwise stay.
  - RUN: each edge:
    - d = A[0]^B[0]^borrow
    - borrow <= (~A[0]&B[0]) | (~(A[0]^B[0])&borrow)
    - d is shifted into the result register MSB-first-in (right shift), so bit i lands at diff[i] after WIDTH shifts.
    - A and B shift right; cnt++.
    - When cnt==WIDTH-1 on an edge, that edge processes the last bit and moves to DONE.
  - DONE: done=1, busy=0, diff and bout valid (bout = final borrow). Next edge:
    - start=1 -> reload and go to RUN (back-to-back operation, no idle gap).
    - start=0 -> go to IDLE.
- Latency: start accepted at edge 0 -> done high after edge WIDTH (WIDTH cycles later). Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly WIDTH cycles per operation.
- start while busy is ignored. Changes on a, b and bin during RUN have no effect.
- diff and bout update only on the edge entering DONE. They hold through IDLE, and must not show partial values while busy.
- Arithmetic: the result is modulo 2^WIDTH. With bin included, the 5-bit range of a-b-bin is -32..31, so bout is the sole indication of unsigned underflow.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. No done is ever produced for the aborted operation.
- start held high continuously: an operation runs every WIDTH+1 cycles.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf = two's-complement overflow = final borrow-into-MSB XOR bout, evaluated on the MSB edge.
  - ovf updates with diff on entry to DONE, holds otherwise, and resets to 0.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- Reset then a=10100, b=10010, bin=0, start one cycle -> busy high 5 cycles; done at start+5; diff=00010, bout=0.
- a=00110, b=01100, bin=1 -> diff=11001 (6-12-1 mod 32 = 25), bout=1.
- a=00000, b=00000, bin=1 -> diff=11111, bout=1. With SERIAL_SUB_OVF_EN, a=10000, b=00001, bin=0 -> diff=01111, bout=0, ovf=1.
- Back-to-back: start held high with a=11111, b=00001, bin=0, then a=00001, b=00010, bin=0 -> first done gives diff=11110, bout=0; second done 6 cycles later gives diff=11111, bout=1.
- Start pulsed mid-RUN with different operands -> ignored; result matches the first operands; only one done pulse.
- rst asserted on the 3rd RUN cycle -> busy, done, diff and bout are 0 immediately. No done until a new start, which then completes normally.
- Random: 1000 random {a,b,bin} vectors -> {bout,diff} == ({1'b0,a} - b - bin) modulo 2^(WIDTH+1).
